// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package loader_pkg;
   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_WIDTH_DEF  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_WRITE,
      ST_DONE,
      ST_ERR
   } state_t;
endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands at bits [8k+7:8k].
module word_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        take_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_ready_o
);

   logic [1:0]  cnt_q;
   logic [23:0] sh_q;

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   // The final byte is combined on the fly so the word is complete in the accepting cycle.
   assign word_o       = {byte_i, sh_q};
   assign word_ready_o = take_i && (cnt_q == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else if (take_i) begin
         cnt_q <= (cnt_q == LAST_IDX) ? 2'd0 : cnt_q + 2'd1;
         sh_q  <= {byte_i, sh_q[23:8]};
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: length-prefixed byte stream -> one instruction memory write per assembled word,
// holding the core until a load has completed successfully.
module instr_mem_loader
   import loader_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_CAPACITY = 10,
   parameter int LEN_WIDTH    = loader_pkg::LEN_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wd,
   output logic                  core_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [LEN_WIDTH-1:0]  words_loaded
);

   localparam logic [LEN_WIDTH-1:0] CAP_L = LEN_WIDTH'(MEM_CAPACITY);

   state_t                  state_q;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [LEN_WIDTH-1:0]    idx_q;
   logic [LEN_WIDTH-1:0]    words_q;
   logic [DATA_WIDTH-1:0]   wd_q;
   logic                    done_q;
   logic                    err_q;
   logic                    loaded_q;

   logic [LEN_WIDTH-1:0]    len_d;
   logic [LEN_WIDTH-1:0]    idx_d;
   logic                    idle_like;
   logic                    start_ok;
   logic                    take;
   logic                    word_ready;
   logic [31:0]             word;

   assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
   assign byte_ready = en && ((state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                              (state_q == ST_DATA));
   assign take       = byte_valid && byte_ready && (state_q == ST_DATA);
   assign start_ok   = en && start && idle_like;
   assign len_d      = LEN_WIDTH'({byte_data, len_q[7:0]});
   assign idx_d      = idx_q + LEN_WIDTH'(1);

   // A frozen WRITE must not strobe memory; it completes on the first enabled cycle.
   assign mem_we       = en && (state_q == ST_WRITE);
   assign mem_addr     = DATA_WIDTH'(idx_q);
   assign mem_wd       = wd_q;
   assign busy         = !idle_like;
   assign core_hold    = !loaded_q || busy;
   assign done         = done_q;
   assign error        = err_q;
   assign words_loaded = words_q;

   word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (start_ok),
      .take_i       (take),
      .byte_i       (byte_data),
      .word_o       (word),
      .word_ready_o (word_ready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         idx_q    <= '0;
         words_q  <= '0;
         wd_q     <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         loaded_q <= 1'b0;
      end else if (en) begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state_q  <= ST_LEN_LO;
                  len_q    <= '0;
                  idx_q    <= '0;
                  words_q  <= '0;
                  done_q   <= 1'b0;
                  err_q    <= 1'b0;
                  loaded_q <= 1'b0;
               end
            end
            ST_LEN_LO: begin
               if (byte_valid) begin
                  len_q[7:0] <= byte_data;
                  state_q    <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (byte_valid) begin
                  len_q <= len_d;
                  if (len_d == '0) begin
                     state_q  <= ST_DONE;
                     done_q   <= 1'b1;
                     loaded_q <= 1'b1;
                  end else if (len_d > CAP_L) begin
                     state_q <= ST_ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (word_ready) begin
                  wd_q    <= word;
                  state_q <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               idx_q   <= idx_d;
               words_q <= words_q + LEN_WIDTH'(1);
               if (idx_d == len_q) begin
                  state_q  <= ST_DONE;
                  done_q   <= 1'b1;
                  loaded_q <= 1'b1;
               end else begin
                  state_q <= ST_DATA;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
